// File: rtl/hazard_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_ctrl_if
//  Description : Pipeline-side signal bundle for the hazard/stall controller.
//                The master modport is used by the pipeline. The slave
//                modport is used by hazard_ctrl.
//  Revision    : 1.0 - initial release
// ============================================================================
interface hazard_ctrl_if #(
    parameter int ADDR_RFILE = 5,
    parameter int CNT_W      = 16
);
    // Hazard sources observed in ID and EX
    logic [ADDR_RFILE-1:0] id_addr_rs;
    logic [ADDR_RFILE-1:0] id_addr_rt;
    logic                  id_use_rs;
    logic                  id_use_rt;
    logic                  id_mdu;
    logic                  ex_mem_rd;
    logic [ADDR_RFILE-1:0] ex_wb_addr;
    logic                  ex_br_taken;

    // Pipeline control and qualifiers
    logic                  pc_en;
    logic                  ifid_en;
    logic                  idex_bubble;
    logic                  ifid_flush;
    logic                  ex_hold;
    logic                  stall_ctrl_t;
    logic                  stall_ctrl_t2;
    logic                  flush_ctrl_t;
    logic [CNT_W-1:0]      stall_cnt;

    modport master (
        output id_addr_rs, id_addr_rt, id_use_rs, id_use_rt, id_mdu,
               ex_mem_rd, ex_wb_addr, ex_br_taken,
        input  pc_en, ifid_en, idex_bubble, ifid_flush, ex_hold,
               stall_ctrl_t, stall_ctrl_t2, flush_ctrl_t, stall_cnt
    );

    modport slave (
        input  id_addr_rs, id_addr_rt, id_use_rs, id_use_rt, id_mdu,
               ex_mem_rd, ex_wb_addr, ex_br_taken,
        output pc_en, ifid_en, idex_bubble, ifid_flush, ex_hold,
               stall_ctrl_t, stall_ctrl_t2, flush_ctrl_t, stall_cnt
    );
endinterface
`default_nettype wire

// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_ctrl
//  Description : Hazard and stall controller for a 5-stage pipeline. It
//                handles load-use stalls, taken-branch flushes and multi-cycle
//                MUL/DIV occupancy of EX. It also produces delayed qualifiers
//                for the forwarding unit and a saturating stall-cycle counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module hazard_ctrl #(
    parameter int ADDR_RFILE = 5,
    parameter int MDU_LAT    = 4,
    parameter int CNT_W      = 16
) (
    input  wire logic   clk,
    input  wire logic   rst,
    hazard_ctrl_if.slave bus
);

    // A counter width of clog2(MDU_LAT) is enough to hold MDU_LAT-1.
    localparam int c_MCNT_W = (MDU_LAT > 2) ? $clog2(MDU_LAT) : 1;

    typedef enum logic [0:0] {
        ST_RUN = 1'b0,
        ST_MDU = 1'b1
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [c_MCNT_W-1:0]   r_mcnt;
    logic [c_MCNT_W-1:0]   w_mcnt_nxt;
    logic                  r_stall_t;
    logic                  r_stall_t2;
    logic                  r_flush_t;
    logic [CNT_W-1:0]      r_stall_cnt;

    logic                  w_lu;
    logic                  w_lu_stall;
    logic                  w_br_flush;
    logic                  w_pc_en;
    logic                  w_ifid_en;
    logic                  w_idex_bubble;
    logic                  w_ifid_flush;
    logic                  w_ex_hold;

    // Load-use detection. A load targeting r0 never creates a dependency.
    always_comb begin
        w_lu = bus.ex_mem_rd
             && (bus.ex_wb_addr != ADDR_RFILE'(0))
             && ((bus.id_use_rs && (bus.id_addr_rs == bus.ex_wb_addr))
              || (bus.id_use_rt && (bus.id_addr_rt == bus.ex_wb_addr)));
    end

    // Next-state and Mealy pipeline controls. Branch beats load-use, and
    // load-use beats MUL/DIV issue.
    always_comb begin
        w_state_nxt   = r_state;
        w_mcnt_nxt    = r_mcnt;
        w_pc_en       = 1'b1;
        w_ifid_en     = 1'b1;
        w_idex_bubble = 1'b0;
        w_ifid_flush  = 1'b0;
        w_ex_hold     = 1'b0;
        w_lu_stall    = 1'b0;
        w_br_flush    = 1'b0;
        case (r_state)
            ST_RUN: begin
                if (bus.ex_br_taken) begin
                    w_ifid_flush  = 1'b1;
                    w_idex_bubble = 1'b1;
                    w_br_flush    = 1'b1;
                end else if (w_lu) begin
                    w_pc_en       = 1'b0;
                    w_ifid_en     = 1'b0;
                    w_idex_bubble = 1'b1;
                    w_lu_stall    = 1'b1;
                end else if (bus.id_mdu) begin
                    w_state_nxt = ST_MDU;
                    w_mcnt_nxt  = c_MCNT_W'(MDU_LAT - 1);
                end
            end
            ST_MDU: begin
                // EX is occupied by the MUL/DIV op, so branch and load
                // hazards cannot originate there.
                w_pc_en    = 1'b0;
                w_ifid_en  = 1'b0;
                w_ex_hold  = 1'b1;
                w_mcnt_nxt = r_mcnt - c_MCNT_W'(1);
                if (r_mcnt == c_MCNT_W'(1)) begin
                    w_state_nxt = ST_RUN;
                end
            end
            default: begin
                w_state_nxt = ST_RUN;
            end
        endcase
    end

    // State register, MUL/DIV occupancy counter and delayed qualifiers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_RUN;
            r_mcnt     <= '0;
            r_stall_t  <= 1'b0;
            r_stall_t2 <= 1'b0;
            r_flush_t  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_mcnt     <= w_mcnt_nxt;
            r_stall_t  <= w_lu_stall;
            r_stall_t2 <= r_stall_t;
            r_flush_t  <= w_br_flush;
        end
    end

    // Saturating count of cycles in which the PC is frozen.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt <= '0;
        end else if (!w_pc_en && (r_stall_cnt != {CNT_W{1'b1}})) begin
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
        end
    end

    assign bus.pc_en         = w_pc_en;
    assign bus.ifid_en       = w_ifid_en;
    assign bus.idex_bubble   = w_idex_bubble;
    assign bus.ifid_flush    = w_ifid_flush;
    assign bus.ex_hold       = w_ex_hold;
    assign bus.stall_ctrl_t  = r_stall_t;
    assign bus.stall_ctrl_t2 = r_stall_t2;
    assign bus.flush_ctrl_t  = r_flush_t;
    assign bus.stall_cnt     = r_stall_cnt;

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hazard_ctrl
//  Description : Self-checking bench for hazard_ctrl. It runs directed
//                scenarios and then random traffic. All of it is compared
//                against a cycle-level behavioural model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_ctrl;

    localparam int c_AW      = 5;
    localparam int c_MDU_LAT = 4;
    localparam int c_CNT_W   = 4;
    localparam int c_CNT_MAX = (1 << c_CNT_W) - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;

    hazard_ctrl_if #(.ADDR_RFILE(c_AW), .CNT_W(c_CNT_W)) hif ();

    hazard_ctrl #(
        .ADDR_RFILE (c_AW),
        .MDU_LAT    (c_MDU_LAT),
        .CNT_W      (c_CNT_W)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (hif.slave)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fails  = 0;

    // Reference model state: remaining MUL/DIV hold cycles, delayed
    // qualifiers and stall counter.
    int m_hold;
    bit m_st1, m_st2, m_fl;
    int m_cnt;

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // Apply one cycle of inputs, compare all outputs with the model, then
    // advance the model across the clock edge.
    task automatic cyc(input bit r, input int rs, input int rt, input bit urs,
                       input bit urt, input bit mdu, input bit ld,
                       input int wb, input bit br);
        bit lu;
        bit e_pc, e_ifid, e_bub, e_fl, e_hold;
        @(posedge clk);
        #1;
        rst              = r;
        hif.id_addr_rs   = c_AW'(rs);
        hif.id_addr_rt   = c_AW'(rt);
        hif.id_use_rs    = urs;
        hif.id_use_rt    = urt;
        hif.id_mdu       = mdu;
        hif.ex_mem_rd    = ld;
        hif.ex_wb_addr   = c_AW'(wb);
        hif.ex_br_taken  = br;
        lu = ld && (wb != 0) && ((urs && rs == wb) || (urt && rt == wb));
        e_pc = 1; e_ifid = 1; e_bub = 0; e_fl = 0; e_hold = 0;
        if (m_hold > 0) begin
            e_pc = 0; e_ifid = 0; e_hold = 1;
        end else if (br) begin
            e_fl = 1; e_bub = 1;
        end else if (lu) begin
            e_pc = 0; e_ifid = 0; e_bub = 1;
        end
        #3;
        chk("pc_en",         int'(hif.pc_en),         int'(e_pc));
        chk("ifid_en",       int'(hif.ifid_en),       int'(e_ifid));
        chk("idex_bubble",   int'(hif.idex_bubble),   int'(e_bub));
        chk("ifid_flush",    int'(hif.ifid_flush),    int'(e_fl));
        chk("ex_hold",       int'(hif.ex_hold),       int'(e_hold));
        chk("stall_ctrl_t",  int'(hif.stall_ctrl_t),  int'(m_st1));
        chk("stall_ctrl_t2", int'(hif.stall_ctrl_t2), int'(m_st2));
        chk("flush_ctrl_t",  int'(hif.flush_ctrl_t),  int'(m_fl));
        chk("stall_cnt",     int'(hif.stall_cnt),     m_cnt);
        if (r) begin
            m_hold = 0; m_st1 = 0; m_st2 = 0; m_fl = 0; m_cnt = 0;
        end else begin
            if (!e_pc && m_cnt < c_CNT_MAX) m_cnt++;
            m_st2 = m_st1;
            m_st1 = (m_hold == 0) && lu && !br;
            m_fl  = (m_hold == 0) && br;
            if (m_hold > 0)   m_hold--;
            else if (!br && !lu && mdu) m_hold = c_MDU_LAT - 1;
        end
    endtask

    task automatic idle();
        cyc(0, 1, 2, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        hif.id_addr_rs  = '0;
        hif.id_addr_rt  = '0;
        hif.id_use_rs   = 1'b0;
        hif.id_use_rt   = 1'b0;
        hif.id_mdu      = 1'b0;
        hif.ex_mem_rd   = 1'b0;
        hif.ex_wb_addr  = '0;
        hif.ex_br_taken = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        m_hold = 0; m_st1 = 0; m_st2 = 0; m_fl = 0; m_cnt = 0;

        // Reset state, then idle.
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(); idle();

        // Load r5 in EX, ID uses rs=5: one stall, then delayed qualifiers.
        cyc(0, 5, 3, 1, 1, 0, 1, 5, 0);
        idle(); idle(); idle();

        // Load r0: never a hazard.
        cyc(0, 0, 0, 1, 1, 0, 1, 0, 0);
        idle();

        // Dependency through rt only.
        cyc(0, 7, 9, 0, 1, 0, 1, 9, 0);
        idle();

        // Branch taken together with a load-use hazard: branch wins.
        cyc(0, 5, 5, 1, 1, 0, 1, 5, 1);
        idle(); idle();

        // MUL/DIV issue followed by its hold cycles; inputs ignored meanwhile.
        cyc(0, 1, 2, 0, 0, 1, 0, 0, 0);
        cyc(0, 6, 6, 1, 1, 1, 1, 6, 1);
        cyc(0, 6, 6, 1, 1, 0, 1, 6, 0);
        cyc(0, 1, 2, 0, 0, 0, 0, 0, 1);
        idle(); idle();

        // Reset asserted during the second hold cycle abandons the op.
        cyc(0, 1, 2, 0, 0, 1, 0, 0, 0);
        idle();
        cyc(1, 1, 2, 0, 0, 0, 0, 0, 0);
        idle(); idle();

        // Twenty back-to-back load-use stalls saturate the 4-bit counter.
        for (int i = 0; i < 20; i++) cyc(0, 5, 0, 1, 0, 0, 1, 5, 0);
        idle(); idle();
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);

        // Random traffic with a small register range to provoke hazards.
        for (int i = 0; i < 3000; i++) begin
            cyc(($urandom_range(99) < 2),
                int'($urandom_range(7)), int'($urandom_range(7)),
                $urandom_range(1) == 1, $urandom_range(1) == 1,
                ($urandom_range(99) < 20),
                $urandom_range(1) == 1, int'($urandom_range(7)),
                ($urandom_range(99) < 15));
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fails);
        $finish;
    end

endmodule
`default_nettype wire
